// File: rtl/fpu_op_sequencer_if.sv
// Handshake and FPU-side signal bundle for fpu_op_sequencer.
// The statistics counters exist only when FPU_SEQ_STATS_EN is defined.
interface fpu_op_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op_a;
  logic [31:0] in_op_b;
  logic [31:0] fpu_op_a;
  logic [31:0] fpu_op_b;
  logic [31:0] fpu_data;
  logic [3:0]  fpu_status;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_status;
  logic        busy;
`ifdef FPU_SEQ_STATS_EN
  logic [15:0] ovf_count;
  logic [15:0] inexact_count;
`endif

  // Sequencer side
  modport slave (
    input  in_valid, in_op_a, in_op_b, fpu_data, fpu_status, out_ready,
    output in_ready, fpu_op_a, fpu_op_b, out_valid, out_data, out_status, busy
`ifdef FPU_SEQ_STATS_EN
    , output ovf_count, inexact_count
`endif
  );

  // Upstream / downstream / FPU side
  modport master (
    output in_valid, in_op_a, in_op_b, fpu_data, fpu_status, out_ready,
    input  in_ready, fpu_op_a, fpu_op_b, out_valid, out_data, out_status, busy
`ifdef FPU_SEQ_STATS_EN
    , input ovf_count, inexact_count
`endif
  );
endinterface

// File: rtl/fpu_op_sequencer.sv
// Queues operand pairs, holds each on a multi-cycle FPU for WAIT_CYCLES, then captures the result.
// Optional macro FPU_SEQ_STATS_EN adds saturating overflow/inexact result counters.
module fpu_op_sequencer #(
  parameter int unsigned WAIT_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic               clock_100Khz,
  input logic               reset,
  fpu_op_sequencer_if.slave bus
);

  localparam int unsigned    PTR_W     = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [7:0]     WAIT_LOAD = 8'(WAIT_CYCLES - 1);
  localparam logic [3:0]     ST_EXACT  = 4'd2;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

  state_t            state, next_state;
  logic [31:0]       mem_a [FIFO_DEPTH];
  logic [31:0]       mem_b [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic [7:0]        wait_cnt;
  logic              full, empty, push, pop, capture;

  assign full         = (count == DEPTH_CNT);
  assign empty        = (count == '0);
  assign push         = bus.in_valid && !full;
  assign bus.in_ready = !full;
  assign bus.busy     = (state != IDLE) || !empty;

  always_ff @(posedge clock_100Khz) begin
    if (push) begin
      mem_a[wr_ptr] <= bus.in_op_a;
      mem_b[wr_ptr] <= bus.in_op_b;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count separates full from empty.
  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (wait_cnt == 8'd0) begin
          capture    = 1'b1;
          next_state = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (!empty) begin
            pop        = 1'b1;
            next_state = WAIT;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // FPU operands change only on a pop, so the FPU inputs stay still while it computes.
  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      bus.fpu_op_a   <= '0;
      bus.fpu_op_b   <= '0;
      wait_cnt       <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_status <= ST_EXACT;
    end else begin
      if (pop) begin
        bus.fpu_op_a <= mem_a[rd_ptr];
        bus.fpu_op_b <= mem_b[rd_ptr];
        wait_cnt     <= WAIT_LOAD;
      end else if (state == WAIT && wait_cnt != 8'd0) begin
        wait_cnt <= wait_cnt - 8'd1;
      end
      if (capture) begin
        bus.out_valid  <= 1'b1;
        bus.out_data   <= bus.fpu_data;
        bus.out_status <= bus.fpu_status;
      end else if (state == HOLD && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef FPU_SEQ_STATS_EN
  localparam logic [3:0] ST_OVERFLOW = 4'd0;
  localparam logic [3:0] ST_INEXACT  = 4'd3;

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      bus.ovf_count     <= '0;
      bus.inexact_count <= '0;
    end else if (capture) begin
      if (bus.fpu_status == ST_OVERFLOW && bus.ovf_count != 16'hFFFF)
        bus.ovf_count <= bus.ovf_count + 16'd1;
      if (bus.fpu_status == ST_INEXACT && bus.inexact_count != 16'hFFFF)
        bus.inexact_count <= bus.inexact_count + 16'd1;
    end
  end
`else
  // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Directed self-checking bench for fpu_op_sequencer using an XOR stub in place of the FPU.
// Covers both WAIT_CYCLES=8/FIFO_DEPTH=4 and the WAIT_CYCLES=1 boundary; stats checked when FPU_SEQ_STATS_EN is set.
module tb_fpu_op_sequencer;

  logic clock_100Khz = 1'b0;
  logic reset        = 1'b1;
  int   vectors      = 0;
  int   miscompares  = 0;
  int   cyc          = 0;

  always #5 clock_100Khz = ~clock_100Khz;
  always @(posedge clock_100Khz) cyc++;

  fpu_op_sequencer_if bus8 ();
  fpu_op_sequencer_if bus1 ();

  fpu_op_sequencer #(.WAIT_CYCLES(8), .FIFO_DEPTH(4)) dut8 (
    .clock_100Khz(clock_100Khz), .reset(reset), .bus(bus8.slave));
  fpu_op_sequencer #(.WAIT_CYCLES(1), .FIFO_DEPTH(2)) dut1 (
    .clock_100Khz(clock_100Khz), .reset(reset), .bus(bus1.slave));

  // Stub FPU: result is A^B, status is B's two low bits
  assign bus8.fpu_data   = bus8.fpu_op_a ^ bus8.fpu_op_b;
  assign bus8.fpu_status = {2'b00, bus8.fpu_op_b[1:0]};
  assign bus1.fpu_data   = bus1.fpu_op_a ^ bus1.fpu_op_b;
  assign bus1.fpu_status = {2'b00, bus1.fpu_op_b[1:0]};

  logic [31:0] pa [6] = '{32'h1111_0000, 32'h0F0F_0F0F, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0000_00FF};
  logic [31:0] pb [6] = '{32'h0000_2222, 32'hFFFF_0000, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0000_0003, 32'h0000_000E};
  logic [31:0] pd [6] = '{32'h1111_2222, 32'hF0F0_0F0F, 32'h1234_5679, 32'h0000_0000, 32'h8000_0003, 32'h0000_00F1};
  logic [3:0]  ps [6] = '{4'd2, 4'd0, 4'd1, 4'd3, 4'd3, 4'd2};

  task automatic step();
    @(posedge clock_100Khz);
    #1;
  endtask

  task automatic do_reset();
    bus8.in_valid = 1'b0; bus8.in_op_a = '0; bus8.in_op_b = '0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_op_a = '0; bus1.in_op_b = '0; bus1.out_ready = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic push_pair8(input logic [31:0] a, input logic [31:0] b);
    int guard = 0;
    bus8.in_op_a  = a;
    bus8.in_op_b  = b;
    bus8.in_valid = 1'b1;
    while (!bus8.in_ready && guard < 200) begin step(); guard++; end
    if (!bus8.in_ready) begin
      vectors++; miscompares++;
      $display("[TB] FAIL push_ready_timeout in_ready=%b required=1", bus8.in_ready);
    end
    step();
    bus8.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    bus8.in_valid = 1'b0; bus8.in_op_a = '0; bus8.in_op_b = '0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_op_a = '0; bus1.in_op_b = '0; bus1.out_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    vectors++; if (bus8.in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_in_ready got=%b exp=1", bus8.in_ready); end
    vectors++; if (bus8.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy got=%b exp=0", bus8.busy); end
    reset = 1'b0;
    step();
    vectors++; if (bus8.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got=%b exp=0", bus8.out_valid); end
    vectors++; if (bus8.out_status !== 4'd2) begin miscompares++; $display("[TB] FAIL reset_out_status got=%0d exp=2", bus8.out_status); end
    vectors++; if (bus8.out_data !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_out_data got=%h exp=0", bus8.out_data); end
    vectors++; if (bus8.fpu_op_a !== 32'h0 || bus8.fpu_op_b !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_fpu_ops got=%h/%h exp=0/0", bus8.fpu_op_a, bus8.fpu_op_b); end
  endtask

  task automatic test_latency();
    bit early = 1'b0;
    do_reset();
    push_pair8(32'h1234_5678, 32'h0000_0F01);
    vectors++; if (bus8.busy !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_busy got=%b exp=1", bus8.busy); end
    vectors++; if (bus8.fpu_op_a !== 32'h0) begin miscompares++; $display("[TB] FAIL lat_no_bypass got=%h exp=0", bus8.fpu_op_a); end
    step();
    vectors++; if (bus8.fpu_op_a !== 32'h1234_5678 || bus8.fpu_op_b !== 32'h0000_0F01) begin miscompares++; $display("[TB] FAIL lat_fpu_ops got=%h/%h exp=12345678/00000f01", bus8.fpu_op_a, bus8.fpu_op_b); end
    for (int i = 0; i < 7; i++) begin
      step();
      if (bus8.out_valid !== 1'b0) early = 1'b1;
    end
    vectors++; if (early) begin miscompares++; $display("[TB] FAIL lat_early_valid got=1 exp=0"); end
    step();
    vectors++; if (bus8.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lat_valid_at_n9 got=%b exp=1", bus8.out_valid); end
    vectors++; if (bus8.out_data !== 32'h1234_5979 || bus8.out_status !== 4'd1) begin miscompares++; $display("[TB] FAIL lat_result got=%h/%0d exp=12345979/1", bus8.out_data, bus8.out_status); end
    step(); step(); step();
    vectors++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== 32'h1234_5979) begin miscompares++; $display("[TB] FAIL lat_hold_stable got=%b/%h exp=1/12345979", bus8.out_valid, bus8.out_data); end
    bus8.out_ready = 1'b1;
    step();
    vectors++; if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL lat_release got=%b/%b exp=0/0", bus8.out_valid, bus8.busy); end
  endtask

  task automatic test_fifo_full();
    int guard = 0;
    int idx;
    bit extra = 1'b0;
    do_reset();
    push_pair8(pa[0], pb[0]);
    while (!bus8.out_valid && guard < 50) begin step(); guard++; end
    vectors++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== pd[0]) begin miscompares++; $display("[TB] FAIL full_first_result got=%b/%h exp=1/%h", bus8.out_valid, bus8.out_data, pd[0]); end
    for (int k = 1; k <= 4; k++) begin
      push_pair8(pa[k], pb[k]);
      vectors++;
      if (bus8.in_ready !== (k < 4)) begin miscompares++; $display("[TB] FAIL full_in_ready_after_push%0d got=%b exp=%b", k, bus8.in_ready, (k < 4)); end
    end
    bus8.in_op_a = pa[5]; bus8.in_op_b = pb[5]; bus8.in_valid = 1'b1;
    step(); step();
    bus8.in_valid = 1'b0;
    vectors++; if (bus8.in_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL full_blocked got=%b exp=0", bus8.in_ready); end
    vectors++; if (bus8.out_valid !== 1'b1 || bus8.out_data !== pd[0] || bus8.out_status !== ps[0]) begin miscompares++; $display("[TB] FAIL full_held_stable got=%b/%h/%0d exp=1/%h/%0d", bus8.out_valid, bus8.out_data, bus8.out_status, pd[0], ps[0]); end
    bus8.out_ready = 1'b1;
    step();
    idx = 1;
    for (int g = 0; g < 100 && idx < 5; g++) begin
      step();
      if (bus8.out_valid) begin
        vectors++;
        if (bus8.out_data !== pd[idx] || bus8.out_status !== ps[idx]) begin miscompares++; $display("[TB] FAIL full_drain%0d got=%h/%0d exp=%h/%0d", idx, bus8.out_data, bus8.out_status, pd[idx], ps[idx]); end
        idx++;
      end
    end
    vectors++; if (idx != 5) begin miscompares++; $display("[TB] FAIL full_drain_count got=%0d exp=5", idx); end
    for (int g = 0; g < 20; g++) begin
      step();
      if (bus8.out_valid) extra = 1'b1;
    end
    vectors++; if (extra || bus8.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL full_fifth_dropped extra=%b busy=%b exp=0/0", extra, bus8.busy); end
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    int idx  = 0;
    int last = 0;
    do_reset();
    bus8.out_ready = 1'b1;
    fork
      begin
        for (int k = 0; k < 6; k++) push_pair8(pa[k], pb[k]);
      end
      begin
        for (int g = 0; g < 200 && idx < 6; g++) begin
          step();
          if (bus8.out_valid) begin
            vectors++;
            if (bus8.out_data !== pd[idx] || bus8.out_status !== ps[idx]) begin miscompares++; $display("[TB] FAIL b2b_result%0d got=%h/%0d exp=%h/%0d", idx, bus8.out_data, bus8.out_status, pd[idx], ps[idx]); end
            if (idx > 0) begin
              vectors++;
              if (cyc - last != 9) begin miscompares++; $display("[TB] FAIL b2b_spacing%0d got=%0d exp=9", idx, cyc - last); end
            end
            last = cyc;
            idx++;
          end
        end
      end
    join
    vectors++; if (idx != 6) begin miscompares++; $display("[TB] FAIL b2b_count got=%0d exp=6", idx); end
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    bit leaked = 1'b0;
    do_reset();
    push_pair8(pa[0], pb[0]);
    push_pair8(pa[1], pb[1]);
    push_pair8(pa[2], pb[2]);
    step(); step();
    reset = 1'b1;
    #1;
    vectors++; if (bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mid_valid_busy got=%b/%b exp=0/0", bus8.out_valid, bus8.busy); end
    vectors++; if (bus8.in_ready !== 1'b1 || bus8.out_status !== 4'd2) begin miscompares++; $display("[TB] FAIL rst_mid_ready_status got=%b/%0d exp=1/2", bus8.in_ready, bus8.out_status); end
    vectors++; if (bus8.fpu_op_a !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mid_fpu_op got=%h exp=0", bus8.fpu_op_a); end
    reset = 1'b0;
    bus8.out_ready = 1'b1;
    for (int g = 0; g < 30; g++) begin
      step();
      if (bus8.out_valid) leaked = 1'b1;
    end
    vectors++; if (leaked) begin miscompares++; $display("[TB] FAIL rst_mid_no_result got=1 exp=0"); end
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_wait_one();
    do_reset();
    bus1.in_op_a = 32'hCAFE_0000; bus1.in_op_b = 32'h0000_BABE; bus1.in_valid = 1'b1;
    step();
    bus1.in_valid = 1'b0;
    vectors++; if (bus1.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL w1_valid_n got=%b exp=0", bus1.out_valid); end
    step();
    vectors++; if (bus1.fpu_op_a !== 32'hCAFE_0000 || bus1.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL w1_n1 got=%h/%b exp=cafe0000/0", bus1.fpu_op_a, bus1.out_valid); end
    step();
    vectors++; if (bus1.out_valid !== 1'b1 || bus1.out_data !== 32'hCAFE_BABE || bus1.out_status !== 4'd2) begin miscompares++; $display("[TB] FAIL w1_n2 got=%b/%h/%0d exp=1/cafebabe/2", bus1.out_valid, bus1.out_data, bus1.out_status); end
    bus1.out_ready = 1'b1;
    step();
    vectors++; if (bus1.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL w1_release got=%b exp=0", bus1.out_valid); end
    bus1.out_ready = 1'b0;
  endtask

`ifdef FPU_SEQ_STATS_EN
  task automatic test_stats();
    do_reset();
    vectors++; if (bus8.ovf_count !== 16'd0 || bus8.inexact_count !== 16'd0) begin miscompares++; $display("[TB] FAIL stats_reset got=%0d/%0d exp=0/0", bus8.ovf_count, bus8.inexact_count); end
    bus8.out_ready = 1'b1;
    push_pair8(32'h0000_0011, 32'h0000_0100);
    push_pair8(32'h0000_0022, 32'h0000_0004);
    push_pair8(32'h0000_0033, 32'h0000_0008);
    push_pair8(32'h0000_0044, 32'h0000_0003);
    push_pair8(32'h0000_0055, 32'h0000_0007);
    for (int g = 0; g < 60; g++) step();
    vectors++; if (bus8.ovf_count !== 16'd3 || bus8.inexact_count !== 16'd2) begin miscompares++; $display("[TB] FAIL stats_counts got=%0d/%0d exp=3/2", bus8.ovf_count, bus8.inexact_count); end
    bus8.out_ready = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_fifo_full();
    test_back_to_back();
    test_reset_mid_wait();
    test_wait_one();
`ifdef FPU_SEQ_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
FPU_OP_SEQUENCER -- requirements
Module: fpu_op_sequencer

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 8: clock cycles the FPU's operands are held before its result is sampled; legal range 1..255.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4: operand-pair FIFO entries; power of two, 2..16.
REQ-003 clock_100Khz  in  1  the single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream operand pair valid.
REQ-006 in_ready  out  1  sequencer can accept a pair.
REQ-007 in_op_a  in  32  operand A: 1-bit sign, 10-bit exponent (bias 511), 21-bit mantissa.
REQ-008 in_op_b  in  32  operand B, same format.
REQ-009 fpu_op_a  out  32  registered operand A driven to the FPU's Op_A_in.
REQ-010 fpu_op_b  out  32  registered operand B driven to the FPU's Op_B_in.
REQ-011 fpu_data  in  32  FPU data_out.
REQ-012 fpu_status  in  4  FPU status_out (OVERFLOW=0, UNDERFLOW=1, EXACT=2, INEXACT=3).
REQ-013 out_valid  out  1  captured result valid.
REQ-014 out_ready  in  1  downstream accepts result.
REQ-015 out_data  out  32  captured result.
REQ-016 out_status  out  4  captured status.
REQ-017 busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 FIFO: push on in_valid && in_ready; in_ready = !full, derived from registered occupancy; no write-through bypass.
REQ-019 FSM states SHALL be IDLE, WAIT and HOLD.
REQ-020 IDLE: if FIFO non-empty, pop head into fpu_op_a/fpu_op_b, load counter with WAIT_CYCLES-1, go to WAIT; else remain in IDLE.
REQ-021 WAIT: counter decrements each cycle; at counter==0, capture fpu_data/fpu_status into out_data/out_status, set out_valid, go to HOLD.
REQ-022 HOLD: out_valid, out_data and out_status SHALL be stable while out_ready is low.
REQ-023 HOLD with out_ready high: clear out_valid; if FIFO non-empty, pop the next pair in the same cycle and go to WAIT (back-to-back); else go to IDLE.
REQ-024 Latency: for a pair pushed at edge N with the block idle and empty, fpu_op_* update at edge N+1, and out_valid rises at edge N+1+WAIT_CYCLES.
REQ-025 fpu_op_a/fpu_op_b SHALL hold their last values outside WAIT, so FPU inputs never glitch.
REQ-026 A push and a pop in the same cycle SHALL leave occupancy unchanged; when full, the push is blocked because in_ready is low.
REQ-027 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH, with a separate full/empty distinction.
REQ-028 Pairs SHALL complete strictly in push order; none dropped or duplicated.

Reset
REQ-029 Assertion of reset at any time, including mid-WAIT or in HOLD, SHALL immediately set: FSM=IDLE, FIFO empty, counter=0, fpu_op_a=fpu_op_b=0, out_valid=0, out_data=0, out_status=EXACT (4'd2).
REQ-030 After reset, in_ready=1 and busy=0; any in-flight pair is discarded.

Configuration
REQ-031 Macro FPU_SEQ_STATS_EN: when defined, add outputs ovf_count[15:0] and inexact_count[15:0].
REQ-032 With FPU_SEQ_STATS_EN, each counter increments at the capture edge when the captured status is OVERFLOW or INEXACT respectively, saturates at 16'hFFFF, and resets to 0.
REQ-033 Without FPU_SEQ_STATS_EN, the ports and counters SHALL be absent, and all other behaviour is identical.

Verification
REQ-034 Real FPU attached, WAIT_CYCLES=8: push A=0x40000000 (2.0), B=0x3FE00000 (1.0) at edge N -> out_valid at edge N+9, out_data=0x40100000 (3.0), out_status=EXACT.
REQ-035 Stub FPU (fpu_data=fpu_op_a^fpu_op_b; fpu_status={2'b0,fpu_op_b[1:0]}): push 4 pairs while out_ready=0 -> in_ready drops after the 4th push; a 5th in_valid is not accepted; the first result is held stable.
REQ-036 Stub, out_ready=1 throughout, 6 pairs streamed -> results emerge in order, one every WAIT_CYCLES+1 cycles, with no loss.
REQ-037 Reset asserted 3 cycles into WAIT with 2 pairs queued -> out_valid=0, busy=0, in_ready=1 and out_status=2 immediately; no result is emitted afterwards.
REQ-038 FPU_SEQ_STATS_EN, stub, 3 pairs with B[1:0]=0 and 2 pairs with B[1:0]=3 -> ovf_count=3, inexact_count=2.
REQ-039 WAIT_CYCLES=1 boundary: single push -> out_valid at edge N+2, with the correct captured data.
